// File: rtl/selector_draw_ctrl.sv
// selector_draw_ctrl
// ------------------
// Renders the 59x66 selector ring sprite into the frame buffer, one row at a
// time. A start request latches the cursor position. The block then walks
// sprite rows 0..SPRITE_H-1 through the external selector ROM. Each row that
// lands on a visible screen line is offered to the frame-buffer arbiter as a
// masked row write, using a valid/ready handshake. Rows that fall below the
// bottom of the screen are skipped without a write.
//
// Optional feature (macro SELECTOR_DRAW_BLINK_EN):
//   Adds input frame_tick and parameter BLINK_FRAMES. A frame counter toggles
//   a visible flag every BLINK_FRAMES ticks. fb_set is sampled from that flag
//   when a draw starts, so alternate draws render or erase the ring. Without
//   the macro, fb_set is constant 1.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   start       one-cycle draw request (ignored while busy)
//   pos_x/pos_y sprite left column / top row, latched on an accepted start
//   frame_tick  one pulse per frame (only with SELECTOR_DRAW_BLINK_EN)
//   busy        high from the cycle after an accepted start until done
//   done        one-cycle pulse after the last row has been handled
//   rom_addr    sprite row address to the selector ROM
//   rom_data    ROM row data, valid ROM_LAT cycles after rom_addr settles
//   fb_valid    row write request to the frame buffer
//   fb_ready    frame buffer accepts the write
//   fb_row      target row = pos_y + sprite row
//   fb_col      target column = latched pos_x
//   fb_mask     bits to modify (the ROM row)
//   fb_set      value written to the masked bits
module selector_draw_ctrl #(
  parameter int SPRITE_W = 59,
  parameter int SPRITE_H = 66,
  parameter int ADDR_W   = 7,
  parameter int ROM_LAT  = 1,
  parameter int Y_W      = 9,
  parameter int X_W      = 10,
  parameter int SCREEN_H = 480
`ifdef SELECTOR_DRAW_BLINK_EN
  , parameter int BLINK_FRAMES = 30
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [X_W-1:0]      pos_x,
  input  logic [Y_W-1:0]      pos_y,
`ifdef SELECTOR_DRAW_BLINK_EN
  input  logic                frame_tick,
`endif
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SPRITE_W-1:0] rom_data,
  output logic                fb_valid,
  input  logic                fb_ready,
  output logic [Y_W-1:0]      fb_row,
  output logic [X_W-1:0]      fb_col,
  output logic [SPRITE_W-1:0] fb_mask,
  output logic                fb_set
);

  localparam int WAIT_W = $clog2(ROM_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_EMIT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_row;
  logic [X_W-1:0]      r_pos_x;
  logic [Y_W-1:0]      r_pos_y;
  logic [WAIT_W-1:0]   r_wait;
  logic [Y_W-1:0]      r_fb_row;
  logic [SPRITE_W-1:0] r_fb_mask;

  logic [Y_W:0]        w_sum;
  logic                w_last_row;
  logic                w_rom_ready;
  logic                w_clipped;
  logic                w_start_ok;
  logic                w_advance;

  // One extra bit so a sprite hanging off the bottom of a 9-bit screen
  // coordinate space still compares correctly against SCREEN_H.
  assign w_sum       = {1'b0, r_pos_y} + (Y_W+1)'(r_row);
  assign w_last_row  = (r_row == ADDR_W'(SPRITE_H - 1));
  // The counter is loaded with ROM_LAT in FETCH. Data is valid in the WAIT
  // cycle that takes it down to zero.
  assign w_rom_ready = (r_wait == WAIT_W'(1));
  assign w_clipped   = (w_sum >= (Y_W+1)'(SCREEN_H));
  assign w_start_ok  = (r_state == S_IDLE) && start;
  // A row is finished either when it is clipped at the end of WAIT, or when
  // its write handshakes in EMIT.
  assign w_advance   = ((r_state == S_WAIT) && w_rom_ready && w_clipped) ||
                       ((r_state == S_EMIT) && fb_ready);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    fb_valid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        busy         = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (w_rom_ready) begin
          if (!w_clipped) begin
            w_state_next = S_EMIT;
          end else if (w_last_row) begin
            w_state_next = S_FINISH;
          end else begin
            w_state_next = S_FETCH;
          end
        end
      end
      S_EMIT: begin
        busy     = 1'b1;
        fb_valid = 1'b1;
        if (fb_ready) begin
          w_state_next = w_last_row ? S_FINISH : S_FETCH;
        end
      end
      S_FINISH: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath. The row counter stops at the last row, so rom_addr never
  // leaves 0..SPRITE_H-1. fb_row/fb_mask only change in WAIT, so they stay
  // stable for the whole EMIT phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row     <= '0;
      r_pos_x   <= '0;
      r_pos_y   <= '0;
      r_wait    <= '0;
      r_fb_row  <= '0;
      r_fb_mask <= '0;
    end else begin
      if (w_start_ok) begin
        r_pos_x <= pos_x;
        r_pos_y <= pos_y;
        r_row   <= '0;
      end
      if (r_state == S_FETCH) begin
        r_wait <= WAIT_W'(ROM_LAT);
      end
      if (r_state == S_WAIT) begin
        r_wait <= r_wait - WAIT_W'(1);
        if (w_rom_ready) begin
          r_fb_mask <= rom_data;
          r_fb_row  <= w_sum[Y_W-1:0];
        end
      end
      if (w_advance && !w_last_row) begin
        r_row <= r_row + ADDR_W'(1);
      end
    end
  end

  // The ROM address is the row counter itself, so it is already stable in
  // the FETCH cycle.
  assign rom_addr = r_row;
  assign fb_row   = r_fb_row;
  assign fb_col   = r_pos_x;
  assign fb_mask  = r_fb_mask;

`ifdef SELECTOR_DRAW_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0] r_frame_cnt;
  logic            r_visible;
  logic            r_fb_set;

  // The blink phase is sampled once per draw, so a draw never mixes
  // rendered and erased rows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_visible   <= 1'b1;
      r_fb_set    <= 1'b1;
    end else begin
      if (frame_tick) begin
        if (r_frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
          r_frame_cnt <= '0;
          r_visible   <= ~r_visible;
        end else begin
          r_frame_cnt <= r_frame_cnt + FC_W'(1);
        end
      end
      if (w_start_ok) begin
        r_fb_set <= r_visible;
      end
    end
  end

  assign fb_set = r_fb_set;
`else
  assign fb_set = 1'b1;
`endif

endmodule

// File: tb/tb_selector_draw_ctrl.sv
// Testbench for selector_draw_ctrl: random and directed draws. A scoreboard
// is filled from a row-by-row model of the sprite placement. A monitor pops
// and compares every accepted frame-buffer write.
module tb_selector_draw_ctrl;

  localparam int SW  = 59;
  localparam int SH  = 66;
  localparam int AW  = 7;
  localparam int YW  = 9;
  localparam int XW  = 10;
  localparam int SCR = 480;
  localparam int RL  = 1;
`ifdef SELECTOR_DRAW_BLINK_EN
  localparam int BF  = 2;
`endif

  typedef struct {
    logic [YW-1:0] row;
    logic [XW-1:0] col;
    logic [SW-1:0] mask;
    logic          set;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [XW-1:0] pos_x = '0;
  logic [YW-1:0] pos_y = '0;
`ifdef SELECTOR_DRAW_BLINK_EN
  logic          frame_tick = 1'b0;
`endif
  logic          busy, done;
  logic [AW-1:0] rom_addr;
  logic [SW-1:0] rom_data;
  logic          fb_valid;
  logic          fb_ready = 1'b0;
  logic [YW-1:0] fb_row;
  logic [XW-1:0] fb_col;
  logic [SW-1:0] fb_mask;
  logic          fb_set;

  always #5 clk = ~clk;

`ifdef SELECTOR_DRAW_BLINK_EN
  selector_draw_ctrl #(.BLINK_FRAMES(BF)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .pos_x(pos_x),
    .pos_y(pos_y),
    .frame_tick(frame_tick),
    .busy(busy),
    .done(done),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .fb_valid(fb_valid),
    .fb_ready(fb_ready),
    .fb_row(fb_row),
    .fb_col(fb_col),
    .fb_mask(fb_mask),
    .fb_set(fb_set)
  );
`else
  selector_draw_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .pos_x(pos_x),
    .pos_y(pos_y),
    .busy(busy),
    .done(done),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .fb_valid(fb_valid),
    .fb_ready(fb_ready),
    .fb_row(fb_row),
    .fb_col(fb_col),
    .fb_mask(fb_mask),
    .fb_set(fb_set)
  );
`endif

  // Selector ROM: one registered cycle of read latency.
  logic [SW-1:0] rom [0:SH-1];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Frame-buffer ready generator: 0 = always ready, 1 = ready one cycle in
  // three, otherwise random. stall_en holds ready low on one chosen row.
  int            ready_mode = 0;
  int            cyc_cnt = 0;
  bit            stall_en = 1'b0;
  logic [YW-1:0] stall_row = '0;

  always @(posedge clk) begin
    #1;
    cyc_cnt++;
    case (ready_mode)
      0:       fb_ready = 1'b1;
      1:       fb_ready = ((cyc_cnt % 3) == 0);
      default: fb_ready = 1'($urandom_range(0, 1));
    endcase
    if (stall_en && fb_valid && fb_row == stall_row) fb_ready = 1'b0;
  end

  // Scoreboard monitor
  exp_t          sb[$];
  exp_t          e;
  int            done_cnt = 0;
  bit            have_prev = 1'b0;
  logic [YW-1:0] p_row;
  logic [XW-1:0] p_col;
  logic [SW-1:0] p_mask;
  logic          p_set;

  always @(negedge clk) begin
    if (!rst_n) begin
      have_prev = 1'b0;
    end else begin
      if (fb_valid) begin
        chk("busy_with_valid", 64'(busy), 64'd1);
        chk("rom_addr_range", 64'(rom_addr < AW'(SH)), 64'd1);
        if (have_prev) begin
          chk("hold_row", 64'(fb_row), 64'(p_row));
          chk("hold_col", 64'(fb_col), 64'(p_col));
          chk("hold_mask", 64'(fb_mask), 64'(p_mask));
          chk("hold_set", 64'(fb_set), 64'(p_set));
        end
        if (fb_ready) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: got row %0d, expected no write", fb_row);
          end else begin
            e = sb.pop_front();
            chk("wr_row", 64'(fb_row), 64'(e.row));
            chk("wr_col", 64'(fb_col), 64'(e.col));
            chk("wr_mask", 64'(fb_mask), 64'(e.mask));
            chk("wr_set", 64'(fb_set), 64'(e.set));
            $display("write row=%0d col=%0d mask=0x%015h set=%0d", fb_row, fb_col, fb_mask, fb_set);
          end
          have_prev = 1'b0;
        end else begin
          p_row  = fb_row;
          p_col  = fb_col;
          p_mask = fb_mask;
          p_set  = fb_set;
          have_prev = 1'b1;
        end
      end else begin
        have_prev = 1'b0;
      end
      if (done) done_cnt++;
    end
  end

  // Reference placement: sprite row r lands on screen line y+r and is
  // written only if that line is on screen.
  task automatic expect_draw(input logic [XW-1:0] x, input logic [YW-1:0] y,
                             input logic set_exp, output int emitted, output int clipped);
    exp_t t;
    emitted = 0;
    clipped = 0;
    for (int r = 0; r < SH; r++) begin
      if (int'(y) + r < SCR) begin
        t.row  = YW'(int'(y) + r);
        t.col  = x;
        t.mask = rom[r];
        t.set  = set_exp;
        sb.push_back(t);
        emitted++;
      end else begin
        clipped++;
      end
    end
  endtask

  // glitch_at >= 0 pulses a second start (with another position) that many
  // cycles into the draw; it must be ignored.
  task automatic draw(input logic [XW-1:0] x, input logic [YW-1:0] y, input logic set_exp,
                      input int mode, input bit check_time, input int glitch_at);
    int emitted, clipped, cyc, d0;
    ready_mode = mode;
    expect_draw(x, y, set_exp, emitted, clipped);
    d0  = done_cnt;
    cyc = 0;
    $display("draw x=%0d y=%0d ready_mode=%0d rows=%0d", x, y, mode, emitted);
    @(posedge clk); #1;
    start = 1'b1; pos_x = x; pos_y = y;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == glitch_at) begin
        start = 1'b1; pos_x = 10'd555; pos_y = 9'd200;
      end else if (cyc == glitch_at + 1) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL draw_timeout: got no done in %0d cycles, expected done", cyc);
    end else if (check_time) begin
      chk("draw_cycles", 64'(cyc), 64'(emitted * (RL + 2) + clipped * (RL + 1) + 1));
    end
    chk("busy_at_done", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("rows_left", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

`ifdef SELECTOR_DRAW_BLINK_EN
  int ticks = 0;
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1; frame_tick = 1'b1;
      @(posedge clk); #1; frame_tick = 1'b0;
      ticks++;
    end
  endtask
  function automatic logic vis_model();
    return ((ticks / BF) % 2) == 0;
  endfunction
`endif

  initial begin
    int cyc, d0;
    logic [63:0] v;
    for (int r = 0; r < SH; r++) begin
      v = {$urandom(), $urandom()};
      rom[r] = v[SW-1:0];
    end
    v = 64'h0000001FC000000; rom[0]  = v[SW-1:0];
    v = 64'h600000000000003; rom[17] = v[SW-1:0];

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_fb_valid", 64'(fb_valid), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_fb_row", 64'(fb_row), 64'd0);
    chk("rst_fb_col", 64'(fb_col), 64'd0);
    chk("rst_fb_mask", 64'(fb_mask), 64'd0);
    chk("rst_fb_set", 64'(fb_set), 64'd1);
    rst_n = 1'b1;

    // Full on-screen draw, then with a slow frame buffer
    draw(10'd100, 9'd10, 1'b1, 0, 1'b1, -1);
    draw(10'd100, 9'd10, 1'b1, 1, 1'b0, -1);
    // Bottom clipping: only screen lines 450..479 are written
    draw(10'd100, 9'd450, 1'b1, 0, 1'b1, -1);
    // Second start mid-draw is ignored
    draw(10'd100, 9'd10, 1'b1, 0, 1'b1, 40);
    // Sprite starts exactly on the last line, and fully off screen
    draw(10'd7, 9'd479, 1'b1, 2, 1'b0, -1);
    draw(10'd1023, 9'd500, 1'b1, 0, 1'b1, -1);
    // Random placements and ready patterns
    for (int i = 0; i < 4; i++) begin
      int m;
      m = $urandom_range(0, 2);
      draw(10'($urandom_range(0, 1023)), 9'($urandom_range(0, 511)), 1'b1, m, (m == 0), -1);
    end

    // Abort with reset while row 20 waits in EMIT
    begin
      int emitted, clipped;
      ready_mode = 0;
      stall_en   = 1'b1;
      stall_row  = 9'd30;
      expect_draw(10'd100, 9'd10, 1'b1, emitted, clipped);
      @(posedge clk); #1;
      start = 1'b1; pos_x = 10'd100; pos_y = 9'd10;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (!(fb_valid && fb_row == 9'd30) && cyc < 1000) begin
        @(negedge clk);
        cyc++;
      end
      if (!(fb_valid && fb_row == 9'd30)) begin
        n_vec++;
        n_err++;
        $display("FAIL abort_wait: got no row 20 write in %0d cycles, expected one", cyc);
      end
      #1;
      rst_n = 1'b0;
      d0 = done_cnt;
      @(posedge clk); #1;
      chk("abort_fb_valid", 64'(fb_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_rom_addr", 64'(rom_addr), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_rows_left", 64'(sb.size()), 64'd46);
      sb.delete();
      stall_en = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    end
    // Redraw from row 0 after the abort
    draw(10'd100, 9'd10, 1'b1, 0, 1'b1, -1);

`ifdef SELECTOR_DRAW_BLINK_EN
    draw(10'd60, 9'd20, vis_model(), 0, 1'b1, -1);
    tick(2);
    draw(10'd60, 9'd20, vis_model(), 0, 1'b1, -1);
    tick(2);
    draw(10'd60, 9'd20, vis_model(), 2, 1'b0, -1);
    tick(1);
    draw(10'd60, 9'd20, vis_model(), 0, 1'b1, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
